multi_cycle_control_unit: RTL
=============================

Name: multi_cycle_control_unit

Overview:
Finite-state controller that sequences the multi-cycle datapath through fetch, decode, execute, memory and write-back.
- Decodes the 6-bit IR opcode, using the ALU zero flag for branches.
- Drives ALUSrcA/ALUSrcB/ALUOp for the ALU.
- Drives PC, IR, register-file and data-memory enables and the writeback/PC muxes.
- Sits between the IR and every datapath control input.

Parameters:
- None. Opcodes and state encodings are fixed in this spec.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-high; forces state to sIF.
- op  input  6  opcode from IR (IR[31:26]), stable from sID until next sIF.
- zero  input  1  ALU zero flag.
- state  output  3  current state, for debug.
- PCWre  output  1  PC loads on the next edge.
- PCSrc  output  2  next-PC select: 00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- IRWre  output  1  IR loads on the next edge.
- InsMemRW  output  1  instruction memory read.
- ExtSel  output  1  immediate extend: 1 sign, 0 zero.
- RegWre  output  1  register-file write enable.
- RegDst  output  2  write register: 00 $31, 01 rt, 10 rd.
- WrRegDSrc  output  1  write data: 0 PC+4, 1 DB bus.
- DBDataSrc  output  1  DB bus: 0 ALU result, 1 memory data.
- mRD  output  1  data memory read.
- mWR  output  1  data memory write.
- ALUSrcA  output  1  ALU A operand: 0 rs, 1 sa.
- ALUSrcB  output  1  ALU B operand: 0 rt, 1 extended immediate.
- ALUOp  output  3  ALU operation: 000 add, 001 sub, 010 slt, 011 srl, 100 sll, 101 or, 110 and, 111 xor.

Behaviour:
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010, sll 011000, slt 100110
  - sw 110000, lw 110001, beq 110100, bne 110101
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is a nop.
- States: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_LD 100, sEXE_BR 101, sEXE_AL 110, sWB_AL 111.
- State register is the only storage. All outputs are combinational from state and op, so no output latency beyond the state register.
- Transitions:
  - sIF -> sID.
  - sID -> sIF for j/jr/jal/nop.
  - sID -> sID for halt (processor frozen until Reset).
  - sID -> sEXE_BR for beq/bne.
  - sID -> sEXE_LS for lw/sw.
  - sID -> sEXE_AL otherwise.
  - sEXE_AL -> sWB_AL -> sIF.
  - sEXE_BR -> sIF.
  - sEXE_LS -> sMEM.
  - sMEM -> sIF for sw; sMEM -> sWB_LD for lw.
  - sWB_LD -> sIF.
- Cycles per instruction: j/jr/jal/nop 2, beq/bne 3, R/I ALU ops 4, sw 4, lw 5.
- Default for every output is 0 unless stated below.
- sIF: IRWre=1, InsMemRW=1.
- sID:
  - ExtSel=0 for ori, 1 otherwise.
  - j: PCWre=1, PCSrc=11.
  - jr: PCWre=1, PCSrc=10.
  - jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
  - nop: PCWre=1, PCSrc=00.
  - halt: PCWre=0.
- ALU controls in all states except sIF:
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addi/ori/lw/sw.
  - ALUOp: add/addi/lw/sw 000, sub/beq/bne 001, slt 010, sll 100, or/ori 101, and 110.
  - ExtSel follows the sID rule in all states except sIF.
- sEXE_BR: PCWre=1. PCSrc=01 if (beq and zero) or (bne and not zero), else 00.
- sMEM: lw mRD=1; sw mWR=1, PCWre=1, PCSrc=00.
- sWB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=01 for addi/ori, 10 otherwise.
- sWB_LD: RegWre=1, WrRegDSrc=1, DBDataSrc=1, RegDst=01, mRD=1, PCWre=1, PCSrc=00.
- Reset:
  - Asserting Reset in any state immediately forces sIF.
  - Reset values: state=000, IRWre=1, InsMemRW=1, all other outputs 0.
  - All write strobes drop the same delta as Reset; no partial register or memory write survives.
  - Leaving Reset starts a fetch on the first rising edge.
- zero is sampled only in sEXE_BR; it is ignored in all other states.

Test Plan:
- Reset asserted mid sWB_AL (add) -> state=000 without waiting for a clock edge, RegWre=0, PCWre=0, IRWre=1. After release, sequence sIF -> sID.
- op=000000 (add) from reset -> states 000, 001, 110, 111, 000. In 111: RegWre=1, RegDst=10, ALUOp=000. PCWre=1 only in 111.
- op=110001 (lw) -> states 000, 001, 010, 011, 100, 000. mRD=1 in 011 and 100. ALUSrcB=1, DBDataSrc=1 in 100. mWR never 1.
- op=110100 (beq) with zero=1 -> in sEXE_BR: PCSrc=01, PCWre=1. Repeat with zero=0 -> PCSrc=00. bne with zero=0 -> PCSrc=01.
- op=111010 (jal) -> sID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1; next state 000. op=111001 (jr) -> PCSrc=10.
- op=111111 (halt) -> state holds 001 for 10 cycles with PCWre=0, RegWre=0, mWR=0. Reset pulse -> 000.

Source files
------------

// File: rtl/multi_cycle_control_unit.sv
// -----------------------------------------------------------------------------
// multi_cycle_control_unit
// Sequencing controller for a multi-cycle datapath. It steps each instruction
// through fetch, decode, execute, memory and write-back and drives every
// datapath control input from the current state and the IR opcode.
//
// Ports
//   CLK        in   1  rising-edge clock
//   Reset      in   1  asynchronous, active-high; forces sIF
//   op         in   6  IR[31:26], stable from sID until the next sIF
//   zero       in   1  ALU zero flag, consulted only in sEXE_BR
//   state      out  3  current state (debug)
//   PCWre      out  1  PC loads on the next edge
//   PCSrc      out  2  00 PC+4, 01 branch target, 10 rs, 11 jump target
//   IRWre      out  1  IR loads on the next edge
//   InsMemRW   out  1  instruction memory read
//   ExtSel     out  1  immediate extend: 1 sign, 0 zero
//   RegWre     out  1  register-file write enable
//   RegDst     out  2  00 $31, 01 rt, 10 rd
//   WrRegDSrc  out  1  write data: 0 PC+4, 1 DB bus
//   DBDataSrc  out  1  DB bus: 0 ALU result, 1 memory data
//   mRD/mWR    out  1  data memory read / write
//   ALUSrcA    out  1  0 rs, 1 sa
//   ALUSrcB    out  1  0 rt, 1 extended immediate
//   ALUOp      out  3  000 add .. 111 xor
//
// The state register is the only storage; every output is a combinational
// function of state and op, so a Reset assertion drops all write strobes in
// the same delta as the state register clears.
// -----------------------------------------------------------------------------
module multi_cycle_control_unit (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] op,
   input  logic       zero,
   output logic [2:0] state,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       ExtSel,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       DBDataSrc,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp
);

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_BNE  = 6'b110101;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [2:0] {
      sIF     = 3'b000,
      sID     = 3'b001,
      sEXE_LS = 3'b010,
      sMEM    = 3'b011,
      sWB_LD  = 3'b100,
      sEXE_BR = 3'b101,
      sEXE_AL = 3'b110,
      sWB_AL  = 3'b111
   } state_e;

   state_e state_q, state_d;

   // Opcode classes
   logic is_branch, is_ls, is_jump, is_nop;
   always_comb begin
      is_branch = (op == OP_BEQ) || (op == OP_BNE);
      is_ls     = (op == OP_LW)  || (op == OP_SW);
      is_jump   = (op == OP_J)   || (op == OP_JR) || (op == OP_JAL);
      // Anything not in the opcode table behaves as a two-cycle nop.
      is_nop    = !((op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) ||
                    (op == OP_OR)  || (op == OP_AND) || (op == OP_ORI)  ||
                    (op == OP_SLL) || (op == OP_SLT) || is_branch ||
                    is_ls || is_jump || (op == OP_HALT));
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state_q <= sIF;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ExtSel    = 1'b0;
      RegWre    = 1'b0;
      RegDst    = 2'b00;
      WrRegDSrc = 1'b0;
      DBDataSrc = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;

      // ALU operand/operation selects are held steady in every non-fetch
      // state so the datapath sees them for the whole instruction.
      if (state_q != sIF) begin
         ExtSel  = (op != OP_ORI);
         ALUSrcA = (op == OP_SLL);
         ALUSrcB = (op == OP_ADDI) || (op == OP_ORI) || is_ls;
         case (op)
            OP_SUB, OP_BEQ, OP_BNE: ALUOp = 3'b001;
            OP_SLT:                 ALUOp = 3'b010;
            OP_SLL:                 ALUOp = 3'b100;
            OP_OR, OP_ORI:          ALUOp = 3'b101;
            OP_AND:                 ALUOp = 3'b110;
            default:                ALUOp = 3'b000;
         endcase
      end

      case (state_q)
         sIF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
            state_d  = sID;
         end
         sID: begin
            if (op == OP_HALT) begin
               state_d = sID;  // frozen until Reset
            end else if (is_jump || is_nop) begin
               PCWre   = 1'b1;
               state_d = sIF;
               if (op == OP_J || op == OP_JAL) PCSrc = 2'b11;
               else if (op == OP_JR)           PCSrc = 2'b10;
               if (op == OP_JAL) begin
                  RegWre    = 1'b1;  // link: $31 <= PC+4
                  RegDst    = 2'b00;
                  WrRegDSrc = 1'b0;
               end
            end else if (is_branch) begin
               state_d = sEXE_BR;
            end else if (is_ls) begin
               state_d = sEXE_LS;
            end else begin
               state_d = sEXE_AL;
            end
         end
         sEXE_AL: state_d = sWB_AL;
         sWB_AL: begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = ((op == OP_ADDI) || (op == OP_ORI)) ? 2'b01 : 2'b10;
            PCWre     = 1'b1;
            state_d   = sIF;
         end
         sEXE_BR: begin
            PCWre = 1'b1;
            if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero))
               PCSrc = 2'b01;
            state_d = sIF;
         end
         sEXE_LS: state_d = sMEM;
         sMEM: begin
            if (op == OP_LW) begin
               mRD     = 1'b1;
               state_d = sWB_LD;
            end else begin
               mWR     = (op == OP_SW);
               PCWre   = 1'b1;
               state_d = sIF;
            end
         end
         sWB_LD: begin
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            DBDataSrc = 1'b1;
            RegDst    = 2'b01;
            mRD       = 1'b1;
            PCWre     = 1'b1;
            state_d   = sIF;
         end
         default: state_d = sIF;
      endcase
   end

   assign state = state_q;

endmodule
